// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage write buffer.
package mem_pkg;

    // Default number of buffered stores.
    localparam int WB_DEPTH = 4;

    // One buffered store.
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wb_entry_t;

    // Buffer operating mode: normal run or draining everything for a fence.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_e;

    // Relationship of a load address to one buffered store address.
    typedef struct packed {
        logic partial;
        logic exact;
    } wb_match_t;

    // Words are 16 bits at byte addresses, so a store one byte either side of
    // the load overlaps it only partially and cannot be forwarded.
    function automatic wb_match_t wb_classify(input logic [15:0] ld_addr,
                                              input logic [15:0] entry_addr);
        logic [15:0] diff;
        wb_match_t   m;
        diff      = ld_addr - entry_addr;
        m.exact   = (diff == 16'h0000);
        m.partial = (diff == 16'h0001) || (diff == 16'hFFFF);
        return m;
    endfunction

endpackage

// File: rtl/mem_wb_fifo.sv
// Circular store queue: entry storage, pointers, occupancy and valid bits.
module mem_wb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t [DEPTH-1:0]   entries,
    output logic      [DEPTH-1:0]   valid,
    output logic      [PTR_W-1:0]   head_ptr,
    output wb_entry_t               head_entry,
    output logic                    full,
    output logic                    empty
);

    logic      [PTR_W-1:0] wr_ptr_r;
    logic      [PTR_W-1:0] rd_ptr_r;
    logic      [CNT_W-1:0] count_r;
    logic      [DEPTH-1:0] valid_r;
    wb_entry_t [DEPTH-1:0] mem_r;

    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic      [DEPTH-1:0] set_mask_s;
    logic      [DEPTH-1:0] clr_mask_s;

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == CNT_W'(0));
    assign push_ok_s  = push && !full;
    assign pop_ok_s   = pop && !empty;
    assign entries    = mem_r;
    assign valid      = valid_r;
    assign head_ptr   = rd_ptr_r;
    assign head_entry = mem_r[rd_ptr_r];

    // One-hot masks for the slot written and the slot retired this cycle.
    always_comb begin
        set_mask_s = push_ok_s ? (DEPTH'(1) << wr_ptr_r) : {DEPTH{1'b0}};
        clr_mask_s = pop_ok_s  ? (DEPTH'(1) << rd_ptr_r) : {DEPTH{1'b0}};
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            valid_r  <= (valid_r & ~clr_mask_s) | set_mask_s;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Store buffer between the MEM stage and main memory, with load forwarding
// from buffered stores and a fence-driven full drain.
module mem_write_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_sys,
    input  logic        st_valid,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [15:0] ld_addr,
    output logic [15:0] ld_data,
    output logic        ld_stall,
    input  logic        fence,
    output logic        flush_done,
    output logic        empty,
    output logic        mem_write_en,
    output logic [15:0] mem_address,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_state_e             state_r;
    wb_state_e             state_next_s;
    wb_entry_t [DEPTH-1:0] entries_s;
    wb_entry_t             head_entry_s;
    wb_entry_t             push_entry_s;
    logic      [DEPTH-1:0] valid_s;
    logic      [PTR_W-1:0] head_ptr_s;
    logic      [PTR_W-1:0] idx_s;
    wb_match_t             match_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  drain_s;
    logic                  partial_s;
    logic                  fwd_hit_s;
    logic      [15:0]      fwd_data_s;

    assign push_entry_s = '{addr: st_addr, data: st_data};
    assign push_s       = st_valid && st_ready;
    assign empty        = empty_s;

    mem_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (drain_s),
        .entries    (entries_s),
        .valid      (valid_s),
        .head_ptr   (head_ptr_s),
        .head_entry (head_entry_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Scan oldest to youngest so the last exact hit wins; flag any partial overlap.
    always_comb begin
        partial_s  = 1'b0;
        fwd_hit_s  = 1'b0;
        fwd_data_s = 16'h0000;
        idx_s      = head_ptr_s;
        match_s    = '{partial: 1'b0, exact: 1'b0};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = head_ptr_s + PTR_W'(i);
            match_s    = wb_classify(ld_addr, entries_s[idx_s].addr);
            partial_s  = partial_s | (valid_s[idx_s] & match_s.partial);
            fwd_data_s = (valid_s[idx_s] && match_s.exact) ? entries_s[idx_s].data : fwd_data_s;
            fwd_hit_s  = fwd_hit_s | (valid_s[idx_s] & match_s.exact);
        end
    end

    // Drain only when the memory port is free of a load, or when forced by a
    // full buffer or a fence; the load port and the write share mem_address.
    always_comb begin
        drain_s      = !empty_s && !halt_sys && ((state_r == FLUSH) || !ld_valid || full_s);
        mem_write_en = drain_s;
        if (drain_s) begin
            mem_address    = head_entry_s.addr;
            mem_write_data = head_entry_s.data;
        end else begin
            mem_address    = ld_addr;
            mem_write_data = 16'h0000;
        end
        st_ready = !full_s && (state_r == RUN);
        ld_stall = ld_valid && (partial_s || drain_s || (state_r == FLUSH));
        ld_data  = fwd_hit_s ? fwd_data_s : mem_rdata;
    end

    // Fence sequencing: leave FLUSH once empty, announcing it for that cycle.
    always_comb begin
        state_next_s = state_r;
        flush_done   = 1'b0;
        case (state_r)
            RUN: begin
                if (fence) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            FLUSH: begin
                if (empty_s) begin
                    state_next_s = RUN;
                    flush_done   = 1'b1;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // Mode register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: a queue-based model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        halt_sys;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_stall;
    logic        fence;
    logic        flush_done;
    logic        empty;
    logic        mem_write_en;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t model_q[$];
    bit   m_flush;

    mem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .halt_sys       (halt_sys),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_stall       (ld_stall),
        .fence          (fence),
        .flush_done     (flush_done),
        .empty          (empty),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_rdata      (mem_rdata)
    );

    // Main memory contents as seen by the load port: a fixed address scramble.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign mem_rdata = mem_f(mem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    // Per-cycle comparison against the model, then advance the model by one edge.
    initial begin : compare
        bit          e_full, e_empty, e_ready, e_drain, e_hit, e_part, e_stall;
        logic [15:0] e_addr, e_fwd, e_ld, diff;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_q.delete();
                m_flush = 1'b0;
                check("rst st_ready", st_ready, 16'd1);
                check("rst empty", empty, 16'd1);
                check("rst mem_write_en", mem_write_en, 16'd0);
                check("rst ld_stall", ld_stall, 16'd0);
                check("rst flush_done", flush_done, 16'd0);
            end else begin
                e_full  = (model_q.size() == DEPTH);
                e_empty = (model_q.size() == 0);
                e_ready = !e_full && !m_flush;
                e_drain = !e_empty && !halt_sys && (m_flush || !ld_valid || e_full);
                e_addr  = ld_addr;
                if (e_drain) e_addr = model_q[0].a;
                e_hit  = 1'b0;
                e_part = 1'b0;
                e_fwd  = 16'h0000;
                foreach (model_q[k]) begin
                    diff = ld_addr - model_q[k].a;
                    if (diff == 16'h0000) begin
                        e_hit = 1'b1;
                        e_fwd = model_q[k].d;
                    end
                    if (diff == 16'h0001 || diff == 16'hFFFF) e_part = 1'b1;
                end
                e_ld    = e_hit ? e_fwd : mem_f(e_addr);
                e_stall = ld_valid && (e_part || e_drain || m_flush);
                check("model st_ready", st_ready, e_ready);
                check("model empty", empty, e_empty);
                check("model mem_write_en", mem_write_en, e_drain);
                check("model mem_address", mem_address, e_addr);
                check("model ld_stall", ld_stall, e_stall);
                check("model ld_data", ld_data, e_ld);
                check("model flush_done", flush_done, m_flush && e_empty);
                if (e_drain) begin
                    check("model mem_write_data", mem_write_data, model_q[0].d);
                    void'(model_q.pop_front());
                end
                if (st_valid && e_ready) model_q.push_back('{a: st_addr, d: st_data});
                if (m_flush && e_empty) m_flush = 1'b0;
                else if (!m_flush && fence) m_flush = 1'b1;
            end
        end
    end

    // Directed scenarios.
    initial begin : stim
        logic [15:0] exp_a;
        rst      = 1'b1;
        halt_sys = 1'b0;
        st_valid = 1'b0;
        st_addr  = 16'h0000;
        st_data  = 16'h0000;
        ld_valid = 1'b1;
        ld_addr  = 16'h0800;
        fence    = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("reset st_ready", st_ready, 16'd1);
        check("reset empty", empty, 16'd1);
        check("reset ld_stall", ld_stall, 16'd0);
        tick();
        tick();
        rst = 1'b1;

        // Forward from a store pushed on the previous edge.
        store(16'h0010, 16'hBEEF);
        ld_addr = 16'h0010;
        #3;
        check("fwd beef data", ld_data, 16'hBEEF);
        check("fwd beef stall", ld_stall, 16'd0);
        check("fwd beef no write", mem_write_en, 16'd0);
        tick();
        ld_addr  = 16'h0800;
        ld_valid = 1'b0;
        tick();
        ld_valid = 1'b1;
        #3;
        check("fwd beef drained", empty, 16'd1);

        // Youngest of two same-address stores wins.
        store(16'h0010, 16'h1111);
        store(16'h0010, 16'h2222);
        ld_addr = 16'h0010;
        #3;
        check("youngest data", ld_data, 16'h2222);
        check("youngest stall", ld_stall, 16'd0);
        tick();
        ld_addr  = 16'h0800;
        ld_valid = 1'b0;
        tick();
        tick();
        ld_valid = 1'b1;
        #3;
        check("youngest drained", empty, 16'd1);

        // Partial overlap across the address wrap stalls until drained.
        store(16'h0000, 16'hAAAA);
        ld_addr = 16'hFFFF;
        #3;
        check("partial stall 1", ld_stall, 16'd1);
        check("partial no write", mem_write_en, 16'd0);
        tick();
        #3;
        check("partial stall 2", ld_stall, 16'd1);
        tick();
        ld_valid = 1'b0;
        #3;
        check("partial drain en", mem_write_en, 16'd1);
        check("partial drain addr", mem_address, 16'h0000);
        check("partial drain data", mem_write_data, 16'hAAAA);
        tick();
        ld_valid = 1'b1;
        #3;
        check("partial released stall", ld_stall, 16'd0);
        check("partial mem data", ld_data, 16'hA5A5);
        tick();

        // Fill to full with a load held: drain is forced and the load stalls.
        ld_addr = 16'h0800;
        store(16'h0100, 16'h1001);
        store(16'h0102, 16'h1002);
        store(16'h0104, 16'h1003);
        store(16'h0106, 16'h1004);
        #3;
        check("full st_ready", st_ready, 16'd0);
        check("full forced drain", mem_write_en, 16'd1);
        check("full drain addr", mem_address, 16'h0100);
        check("full ld_stall", ld_stall, 16'd1);
        tick();
        #3;
        check("after full no drain", mem_write_en, 16'd0);
        check("after full stall", ld_stall, 16'd0);

        // Halt freezes draining of the three remaining entries.
        halt_sys = 1'b1;
        ld_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #3;
            check("halt no write", mem_write_en, 16'd0);
            check("halt st_ready", st_ready, 16'd1);
            tick();
        end
        halt_sys = 1'b0;
        exp_a = 16'h0102;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("release write", mem_write_en, 16'd1);
            check("release order", mem_address, exp_a);
            exp_a = exp_a + 16'h0002;
            tick();
        end
        #3;
        check("release empty", empty, 16'd1);
        check("release idle", mem_write_en, 16'd0);

        // Fence with two entries and a load held high.
        ld_valid = 1'b1;
        store(16'h0200, 16'h2001);
        store(16'h0202, 16'h2002);
        fence = 1'b1;
        tick();
        fence = 1'b0;
        #3;
        check("fence st_ready", st_ready, 16'd0);
        check("fence write 1", mem_write_en, 16'd1);
        check("fence addr 1", mem_address, 16'h0200);
        check("fence stall", ld_stall, 16'd1);
        check("fence not done", flush_done, 16'd0);
        tick();
        #3;
        check("fence write 2", mem_write_en, 16'd1);
        check("fence addr 2", mem_address, 16'h0202);
        tick();
        #3;
        check("fence done", flush_done, 16'd1);
        check("fence empty", empty, 16'd1);
        tick();
        #3;
        check("fence done once", flush_done, 16'd0);
        check("fence back run", st_ready, 16'd1);

        // Fence while already empty.
        fence = 1'b1;
        tick();
        fence = 1'b0;
        #3;
        check("empty fence done", flush_done, 16'd1);
        check("empty fence st_ready", st_ready, 16'd0);
        tick();
        #3;
        check("empty fence once", flush_done, 16'd0);
        check("empty fence run", st_ready, 16'd1);

        // Simultaneous push and pop while no load is pending.
        ld_valid = 1'b0;
        store(16'h0300, 16'h4001);
        store(16'h0302, 16'h4002);
        store(16'h0304, 16'h4003);
        ld_valid = 1'b1;
        ld_addr  = 16'h0304;
        #3;
        check("pushpop fwd", ld_data, 16'h4003);
        check("pushpop one left", empty, 16'd0);
        ld_valid = 1'b0;
        tick();
        ld_valid = 1'b1;
        ld_addr  = 16'h0800;
        tick();

        // Reset in the middle of a drain discards the rest.
        store(16'h0400, 16'h5001);
        store(16'h0402, 16'h5002);
        store(16'h0404, 16'h5003);
        ld_valid = 1'b0;
        #3;
        check("midreset draining", mem_write_en, 16'd1);
        tick();
        rst = 1'b0;
        #3;
        check("midreset empty", empty, 16'd1);
        check("midreset no write", mem_write_en, 16'd0);
        tick();
        tick();
        rst = 1'b1;
        #3;
        check("post reset empty", empty, 16'd1);
        check("post reset no write", mem_write_en, 16'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered stores (power of two, 2..8).
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: halt_sys  in  1  system halt, freezes draining.
REQ-005 SHALL have port: st_valid  in  1  store request from MEM stage.
REQ-006 SHALL have ports: st_addr  in  16  store byte address; st_data  in  16  store word.
REQ-007 SHALL have port: st_ready  out  1  store accepted when st_valid & st_ready at clk edge.
REQ-008 SHALL have ports: ld_valid  in  1  load request; ld_addr  in  16  load byte address.
REQ-009 SHALL have ports: ld_data  out  16  load result; ld_stall  out  1  load cannot complete this cycle.
REQ-010 SHALL have port: fence  in  1  request full drain.
REQ-011 SHALL have ports: flush_done  out  1  one-cycle drain-complete pulse; empty  out  1  no entries held.
REQ-012 SHALL have ports to main memory: mem_write_en  out  1; mem_address  out  16; mem_write_data  out  16; mem_rdata  in  16 (big-endian word at mem_address).

Function
REQ-013 SHALL hold up to DEPTH entries {addr, data} in FIFO order; count width clog2(DEPTH)+1, pointers wrap modulo DEPTH.
REQ-014 SHALL drive st_ready = !full & (state == RUN); a store pushed at edge N SHALL be visible to forwarding from cycle N+1.
REQ-015 SHALL compute drain = !empty & !halt_sys & (state == FLUSH | !ld_valid | full); mem_write_en = drain.
REQ-016 SHALL drive mem_address = head.addr and mem_write_data = head.data when drain, else mem_address = ld_addr; head pops at the same edge.
REQ-017 SHALL allow simultaneous push and pop; count unchanged, pointers both advance.
REQ-018 SHALL classify each valid entry against ld_addr by d = ld_addr - entry.addr modulo 2^16: exact if d == 0, partial if d == 16'h0001 or 16'hFFFF.
REQ-019 SHALL assert ld_stall when ld_valid & (any partial match | drain | state == FLUSH); ld_stall = 0 when ld_valid = 0.
REQ-020 SHALL drive ld_data combinationally (zero latency) = data of youngest exact-matching entry, else mem_rdata.
REQ-021 SHALL implement FSM RUN/FLUSH: RUN -> FLUSH on fence; FLUSH -> RUN when empty, pulsing flush_done for exactly that one cycle.
REQ-022 SHALL, with fence asserted while already empty, pulse flush_done on the next cycle and return to RUN.
REQ-023 SHALL, while halt_sys = 1, keep mem_write_en = 0, retain contents, and still accept stores if not full.

Reset
REQ-024 SHALL on rst = 0 asynchronously clear pointers, count and entry valid bits and enter RUN; entry data need not reset.
REQ-025 SHALL during and after reset drive st_ready = 1, empty = 1, mem_write_en = 0, ld_stall = 0, flush_done = 0.
REQ-026 SHALL on reset mid-drain discard all buffered stores with no further memory write.

Structure
REQ-027 SHALL place WB_DEPTH default, wb_entry_t struct {addr, data} and wb_state_e {RUN, FLUSH} in shared package mem_pkg.
REQ-028 SHALL implement entry storage and pointers in one sub-module mem_wb_fifo; match/forward logic and FSM stay in the top.

Verification
REQ-029 SHALL cover: store 0x0010 <- 0xBEEF, next cycle load 0x0010 -> ld_data = 0xBEEF, ld_stall = 0, no memory write that cycle.
REQ-030 SHALL cover: stores to 0x0010 (0x1111) then 0x0010 (0x2222), load 0x0010 -> ld_data = 0x2222.
REQ-031 SHALL cover: buffered store at 0x0000, load 0xFFFF -> ld_stall = 1 until entry drained, then ld_data = mem_rdata.
REQ-032 SHALL cover: 4 stores with ld_valid held high -> st_ready = 0 after 4th push, drain forced, ld_stall = 1 during the drain cycle.
REQ-033 SHALL cover: 3 entries, halt_sys = 1 for 5 cycles -> no mem_write_en; release -> 3 writes in order, empty = 1.
REQ-034 SHALL cover: fence with 2 entries -> st_ready = 0, 2 consecutive writes, flush_done pulses once, state back to RUN.
